fpu_iter_adapter: RTL and testbench

FPU_ITER_ADAPTER -- requirements
Module: fpu_iter_adapter

---
 rtl/fpu_iter_adapter.sv | 232 +++++++++++++++++++++++
 tb/tb_fpu_iter_adapter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_iter_adapter.sv
// fpu_iter_adapter
//
// Wraps an iterative (multi-cycle) FPU core behind a valid/ready request
// port and a valid/ready result port. One operation is in flight at any
// time. Operands and control fields are registered and presented to the
// core on core_*. The core is launched with a one-cycle core_start_o pulse,
// and the adapter then waits for core_done_i. Each result is queued with its
// status flags and request tag in a small first-word-fall-through FIFO.
//
// Optional feature: define FPU_ITER_ADAPTER_TIMEOUT_EN to add a run-cycle
// watchdog. If the core has not signalled done after TIMEOUT cycles in RUN,
// the adapter queues result 0 with status NV (5'b10000), pulses
// core_abort_o and returns to IDLE. Without the macro RUN waits forever.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   in_valid_i / in_ready_o            request handshake
//   operands_i                         {c, b, a}, a in the LSBs
//   op_i, rnd_mode_i, src_fmt_i,
//   dst_fmt_i, tag_i                   request fields
//   flush_i                            drop the in-flight op and all queued results
//   out_valid_o / out_ready_i          result handshake
//   result_o, status_o, tag_o          head of the result FIFO (0 when empty)
//   busy_o                             op in flight or result queued
//   core_start_o, core_abort_o         one-cycle core control pulses
//   core_opa_o..core_dst_fmt_o         registered operands and fields for the core
//   core_done_i, core_result_i,
//   core_status_i                      core completion
module fpu_iter_adapter #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 5,
  parameter int OP_WIDTH  = 5,
  parameter int DEPTH     = 2,
  parameter int TIMEOUT   = 127
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [3*WIDTH-1:0]     operands_i,
  input  logic [OP_WIDTH-1:0]    op_i,
  input  logic [2:0]             rnd_mode_i,
  input  logic [2:0]             src_fmt_i,
  input  logic [2:0]             dst_fmt_i,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       result_o,
  output logic [4:0]             status_o,
  output logic [TAG_WIDTH-1:0]   tag_o,
  output logic                   busy_o,
  output logic                   core_start_o,
  output logic                   core_abort_o,
  output logic [WIDTH-1:0]       core_opa_o,
  output logic [WIDTH-1:0]       core_opb_o,
  output logic [WIDTH-1:0]       core_opc_o,
  output logic [OP_WIDTH-1:0]    core_op_o,
  output logic [2:0]             core_rnd_o,
  output logic [2:0]             core_src_fmt_o,
  output logic [2:0]             core_dst_fmt_o,
  input  logic                   core_done_i,
  input  logic [WIDTH-1:0]       core_result_i,
  input  logic [4:0]             core_status_i
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = WIDTH + 5 + TAG_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       push_result;
  logic [4:0]             push_status;
  logic [TAG_WIDTH-1:0]   tag_q;

  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [ENTRY_W-1:0]     head;
  logic                   fifo_nonempty;

  // Pointer advance with wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request side: a FIFO slot is reserved at accept, so the eventual push
  // can never overflow. Gated by rst_ni so the port reads 0 during reset.
  assign fifo_nonempty = (count != '0);
  assign in_ready_o    = rst_ni && (state == IDLE) && (count < CNT_W'(DEPTH)) && !flush_i;
  assign accept        = in_valid_i && in_ready_o;
  assign pop           = fifo_nonempty && out_ready_i;
  assign busy_o        = (state != IDLE) || fifo_nonempty;

`ifdef FPU_ITER_ADAPTER_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TCNT_W-1:0] run_cnt;
  logic              timeout_hit;

  // run_cnt holds the index of the current RUN cycle (0 on the first one).
  assign timeout_hit = (state == RUN) && (run_cnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt <= '0;
    end else if (state == LAUNCH) begin
      run_cnt <= '0;
    end else if (state == RUN) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end
`endif

  // Control FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control FSM: next state, core pulses and FIFO push selection
  always_comb begin
    state_nxt    = state;
    core_start_o = 1'b0;
    core_abort_o = 1'b0;
    push         = 1'b0;
    push_result  = core_result_i;
    push_status  = core_status_i;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        core_start_o = 1'b1;
        state_nxt    = RUN;
      end
      RUN: begin
        if (core_done_i) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef FPU_ITER_ADAPTER_TIMEOUT_EN
        else if (timeout_hit) begin
          push         = 1'b1;
          push_result  = '0;
          push_status  = 5'b10000;
          core_abort_o = 1'b1;
          state_nxt    = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    // Flush wins over everything: a coinciding done is dropped and the core
    // is told to abandon whatever it was working on.
    if (flush_i) begin
      state_nxt    = IDLE;
      push         = 1'b0;
      core_abort_o = (state != IDLE);
    end
  end

  // Operand/field capture: held until the next accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_opa_o     <= '0;
      core_opb_o     <= '0;
      core_opc_o     <= '0;
      core_op_o      <= '0;
      core_rnd_o     <= '0;
      core_src_fmt_o <= '0;
      core_dst_fmt_o <= '0;
      tag_q          <= '0;
    end else if (accept) begin
      core_opa_o     <= operands_i[WIDTH-1:0];
      core_opb_o     <= operands_i[2*WIDTH-1:WIDTH];
      core_opc_o     <= operands_i[3*WIDTH-1:2*WIDTH];
      core_op_o      <= op_i;
      core_rnd_o     <= rnd_mode_i;
      core_src_fmt_o <= src_fmt_i;
      core_dst_fmt_o <= dst_fmt_i;
      tag_q          <= tag_i;
    end
  end

  // Result FIFO: pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result FIFO: storage (contents are masked at the output when empty)
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {push_result, push_status, tag_q};
  end

  assign head        = mem[rd_ptr];
  assign out_valid_o = fifo_nonempty;
  assign result_o    = fifo_nonempty ? head[ENTRY_W-1 -: WIDTH]       : '0;
  assign status_o    = fifo_nonempty ? head[TAG_WIDTH +: 5]           : '0;
  assign tag_o       = fifo_nonempty ? head[TAG_WIDTH-1:0]            : '0;

endmodule

// File: tb/tb_fpu_iter_adapter.sv
module tb_fpu_iter_adapter;

  localparam int WIDTH     = 64;
  localparam int TAG_WIDTH = 5;
  localparam int OP_WIDTH  = 5;
  localparam int DEPTH     = 2;
  localparam int TIMEOUT   = 10;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 in_valid_i = 1'b0;
  logic                 in_ready_o;
  logic [3*WIDTH-1:0]   operands_i = '0;
  logic [OP_WIDTH-1:0]  op_i = '0;
  logic [2:0]           rnd_mode_i = '0;
  logic [2:0]           src_fmt_i = '0;
  logic [2:0]           dst_fmt_i = '0;
  logic [TAG_WIDTH-1:0] tag_i = '0;
  logic                 flush_i = 1'b0;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b0;
  logic [WIDTH-1:0]     result_o;
  logic [4:0]           status_o;
  logic [TAG_WIDTH-1:0] tag_o;
  logic                 busy_o;
  logic                 core_start_o;
  logic                 core_abort_o;
  logic [WIDTH-1:0]     core_opa_o;
  logic [WIDTH-1:0]     core_opb_o;
  logic [WIDTH-1:0]     core_opc_o;
  logic [OP_WIDTH-1:0]  core_op_o;
  logic [2:0]           core_rnd_o;
  logic [2:0]           core_src_fmt_o;
  logic [2:0]           core_dst_fmt_o;
  logic                 core_done_i = 1'b0;
  logic [WIDTH-1:0]     core_result_i = '0;
  logic [4:0]           core_status_i = '0;

  int tests  = 0;
  int failed = 0;
  int aborts;
  int abort_cyc;
  int valid_cyc;
  int bad_busy;
  int bad_valid;

  fpu_iter_adapter #(
    .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .OP_WIDTH(OP_WIDTH),
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .operands_i(operands_i), .op_i(op_i), .rnd_mode_i(rnd_mode_i),
    .src_fmt_i(src_fmt_i), .dst_fmt_i(dst_fmt_i), .tag_i(tag_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .busy_o(busy_o),
    .core_start_o(core_start_o), .core_abort_o(core_abort_o),
    .core_opa_o(core_opa_o), .core_opb_o(core_opb_o), .core_opc_o(core_opc_o),
    .core_op_o(core_op_o), .core_rnd_o(core_rnd_o),
    .core_src_fmt_o(core_src_fmt_o), .core_dst_fmt_o(core_dst_fmt_o),
    .core_done_i(core_done_i), .core_result_i(core_result_i),
    .core_status_i(core_status_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accept one op in the current (IDLE) cycle, complete it on the first RUN
  // cycle, and return 2 units into the cycle after done (result queued).
  task automatic do_op(input logic [TAG_WIDTH-1:0] t, input logic [63:0] r,
                       input logic [4:0] s, input logic pop_at_done);
    in_valid_i = 1'b1;
    tag_i      = t;
    op_i       = OP_WIDTH'(t);
    operands_i = {r, r, r};
    #2;
    check("op_accept_ready", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    #2;
    check("op_launch_start", core_start_o, 1);
    tick();
    core_done_i   = 1'b1;
    core_result_i = r;
    core_status_i = s;
    out_ready_i   = pop_at_done;
    tick();
    core_done_i   = 1'b0;
    core_result_i = '0;
    core_status_i = '0;
    out_ready_i   = 1'b0;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_core_start", core_start_o, 0);
    check("rst_core_abort", core_abort_o, 0);
    check("rst_core_opa", core_opa_o, 0);
    check("rst_result", result_o, 0);
    #1 rst_ni = 1'b1;

    // Single op: accept at c0, start at c1, done at c4, valid at c5
    tick();
    operands_i = {64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    op_i = 5'd3; tag_i = 5'd5; rnd_mode_i = 3'd2; src_fmt_i = 3'd1; dst_fmt_i = 3'd4;
    in_valid_i = 1'b1;
    #2;
    check("c0_in_ready", in_ready_o, 1);
    check("c0_start", core_start_o, 0);
    tick();
    in_valid_i = 1'b0;
    operands_i = '0;
    #2;
    check("c1_start", core_start_o, 1);
    check("c1_opa", core_opa_o, 64'hAAAA_0000_0000_0001);
    check("c1_opb", core_opb_o, 64'hBBBB_0000_0000_0002);
    check("c1_opc", core_opc_o, 64'hCCCC_0000_0000_0003);
    check("c1_op", core_op_o, 3);
    check("c1_rnd", core_rnd_o, 2);
    check("c1_src_fmt", core_src_fmt_o, 1);
    check("c1_dst_fmt", core_dst_fmt_o, 4);
    check("c1_busy", busy_o, 1);
    check("c1_in_ready", in_ready_o, 0);
    tick();
    #2;
    check("c2_start", core_start_o, 0);
    tick();
    #2;
    check("c3_start", core_start_o, 0);
    tick();
    core_done_i = 1'b1; core_result_i = 64'h3FF0_0000_0000_0000; core_status_i = 5'b00001;
    #2;
    check("c4_out_valid", out_valid_o, 0);
    tick();
    core_done_i = 1'b0; core_result_i = '0; core_status_i = '0;
    #2;
    check("c5_out_valid", out_valid_o, 1);
    check("c5_result", result_o, 64'h3FF0_0000_0000_0000);
    check("c5_status", status_o, 5'b00001);
    check("c5_tag", tag_o, 5);
    check("c5_opa_held", core_opa_o, 64'hAAAA_0000_0000_0001);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    core_done_i = 1'b1; core_result_i = 64'h123;
    #2;
    check("c6_popped", out_valid_o, 0);
    check("c6_busy", busy_o, 0);
    tick();
    core_done_i = 1'b0; core_result_i = '0;
    #2;
    check("idle_done_ignored", out_valid_o, 0);
    check("idle_done_busy", busy_o, 0);

    // Backpressure with DEPTH=2
    do_op(5'd1, 64'h1111, 5'h01, 1'b0);
    check("bp1_valid", out_valid_o, 1);
    check("bp1_tag", tag_o, 1);
    check("bp1_in_ready", in_ready_o, 1);
    do_op(5'd2, 64'h2222, 5'h02, 1'b0);
    check("bp2_in_ready", in_ready_o, 0);
    check("bp2_head_tag", tag_o, 1);
    check("bp2_head_result", result_o, 64'h1111);
    out_ready_i = 1'b1;
    #1;
    check("bp_pop_cycle_ready", in_ready_o, 0);
    tick();
    out_ready_i = 1'b0;
    #1;
    check("bp_after_pop_ready", in_ready_o, 1);
    check("bp_second_tag", tag_o, 2);
    check("bp_second_result", result_o, 64'h2222);
    check("bp_second_status", status_o, 5'h02);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    #1;
    check("bp_drained", out_valid_o, 0);

    // Push and pop in the same cycle with one entry queued
    do_op(5'd3, 64'h3333, 5'h04, 1'b0);
    do_op(5'd4, 64'h4444, 5'h08, 1'b1);
    #1;
    check("pp_valid", out_valid_o, 1);
    check("pp_tag", tag_o, 4);
    check("pp_result", result_o, 64'h4444);
    check("pp_status", status_o, 5'h08);
    check("pp_in_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    #1;
    check("pp_count_was_one", out_valid_o, 0);

    // Flush in RUN: accept c0, flush c2, late done c4
    tick();
    in_valid_i = 1'b1; tag_i = 5'd6;
    #2;
    check("fl_accept_ready", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    #2;
    check("fl_c1_abort", core_abort_o, 0);
    tick();
    flush_i = 1'b1;
    #2;
    check("fl_c2_abort", core_abort_o, 1);
    check("fl_c2_in_ready", in_ready_o, 0);
    tick();
    flush_i = 1'b0;
    #2;
    check("fl_c3_abort", core_abort_o, 0);
    check("fl_c3_busy", busy_o, 0);
    tick();
    core_done_i = 1'b1; core_result_i = 64'h5555;
    tick();
    core_done_i = 1'b0; core_result_i = '0;
    #2;
    check("fl_c5_out_valid", out_valid_o, 0);
    check("fl_c5_busy", busy_o, 0);

    // Flush coinciding with done, with one result already queued
    do_op(5'd7, 64'h7777, 5'h00, 1'b0);
    in_valid_i = 1'b1; tag_i = 5'd8;
    tick();
    in_valid_i = 1'b0;
    tick();
    core_done_i = 1'b1; core_result_i = 64'h8888; flush_i = 1'b1;
    #2;
    check("fd_abort", core_abort_o, 1);
    tick();
    core_done_i = 1'b0; core_result_i = '0; flush_i = 1'b0;
    #2;
    check("fd_out_valid", out_valid_o, 0);
    check("fd_busy", busy_o, 0);

`ifdef FPU_ITER_ADAPTER_TIMEOUT_EN
    // Timeout: accept at c0, RUN from c2, expire in the 10th RUN cycle (c11)
    in_valid_i = 1'b1; tag_i = 5'd10;
    #1;
    tick();
    in_valid_i = 1'b0;
    aborts = 0; abort_cyc = -1; valid_cyc = -1;
    for (int c = 1; c <= 40 && valid_cyc < 0; c++) begin
      #2;
      if (core_abort_o) begin
        aborts++;
        abort_cyc = c;
      end
      if (out_valid_o) valid_cyc = c;
      else tick();
    end
    check("to_valid_cycle", valid_cyc, 12);
    check("to_abort_count", aborts, 1);
    check("to_abort_cycle", abort_cyc, 11);
    check("to_result", result_o, 0);
    check("to_status", status_o, 5'b10000);
    check("to_tag", tag_o, 10);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    #2;
    check("to_drained", busy_o, 0);
`else
    // No timeout: the op stays in RUN indefinitely
    in_valid_i = 1'b1; tag_i = 5'd10;
    #1;
    tick();
    in_valid_i = 1'b0;
    bad_busy = 0; bad_valid = 0;
    for (int c = 0; c < 1000; c++) begin
      #2;
      if (!busy_o) bad_busy++;
      if (out_valid_o) bad_valid++;
      tick();
    end
    check("nto_busy_dropped", bad_busy, 0);
    check("nto_out_valid_seen", bad_valid, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #2;
    check("nto_flushed_busy", busy_o, 0);
`endif

    // Asynchronous reset mid-RUN with a result queued
    do_op(5'd11, 64'hBBBB, 5'h01, 1'b0);
    in_valid_i = 1'b1; tag_i = 5'd12;
    tick();
    in_valid_i = 1'b0;
    #2;
    check("ar_launch_start", core_start_o, 1);
    tick();
    #2;
    check("ar_run_busy", busy_o, 1);
    check("ar_run_valid", out_valid_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("ar_out_valid", out_valid_o, 0);
    check("ar_busy", busy_o, 0);
    check("ar_core_start", core_start_o, 0);
    check("ar_core_abort", core_abort_o, 0);
    check("ar_in_ready", in_ready_o, 0);
    check("ar_core_opa", core_opa_o, 0);
    check("ar_tag", tag_o, 0);
    tick();
    #2 rst_ni = 1'b1;
    tick();
    core_done_i = 1'b1; core_result_i = 64'hDEAD;
    tick();
    core_done_i = 1'b0; core_result_i = '0;
    #2;
    check("ar_stale_done_ignored", out_valid_o, 0);
    check("ar_stale_done_busy", busy_o, 0);
    do_op(5'd13, 64'hD00D, 5'h10, 1'b0);
    check("ar_recover_valid", out_valid_o, 1);
    check("ar_recover_tag", tag_o, 13);
    check("ar_recover_result", result_o, 64'hD00D);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
